// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit for the EX stage (mult, multu, div, divu).
// One shift-add or restoring-divide iteration per cycle, then a sign-fix cycle.
module mul_div_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        ErrorFlush,
    output logic        busy,
    output logic        done,
    output logic [31:0] Res_hiE,
    output logic [31:0] Res_loE
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b10;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opr_q, opr_d;
    logic        negq_q, negq_d;   // negP for multiply, negQ for divide
    logic        negr_q, negr_d;
    logic        dz_q, dz_d;
    logic [1:0]  op_q, op_d;
    logic        done_q, done_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;

    logic        is_signed;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [64:0] div_sh;
    logic [32:0] div_trial;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        is_signed = ~op[0];
        mag_a     = (is_signed && srcA[31]) ? (~srcA + 32'd1) : srcA;
        mag_b     = (is_signed && srcB[31]) ? (~srcB + 32'd1) : srcB;

        mul_sum   = acc_q[0] ? ({1'b0, acc_q[63:32]} + {1'b0, opr_q}) : {1'b0, acc_q[63:32]};
        // Partial remainder can reach 33 bits after the shift when the divisor is >= 2^31.
        div_sh    = {acc_q, 1'b0};
        div_trial = div_sh[64:32] - {1'b0, opr_q};

        prod_fix  = negq_q ? (~acc_q + 64'd1) : acc_q;
        quo_fix   = dz_q ? 32'hFFFF_FFFF : (negq_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
        rem_fix   = negr_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opr_d    = opr_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        dz_d     = dz_q;
        op_d     = op_q;
        done_d   = 1'b0;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;

        if (ErrorFlush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_d   = {32'd0, mag_a};
                        opr_d   = mag_b;
                        op_d    = op;
                        negq_d  = is_signed && (srcA[31] ^ srcB[31]);
                        negr_d  = (op == OP_DIV) && srcA[31];
                        dz_d    = (srcB == 32'd0);
                        cnt_d   = 6'd0;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    if (op_q[1] == 1'b0) begin
                        acc_d = {mul_sum, acc_q[31:1]};
                    end else if (!div_trial[32]) begin
                        acc_d = {div_trial[31:0], div_sh[31:1], 1'b1};
                    end else begin
                        acc_d = div_sh[63:0];
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(ITER - 1)) state_d = FIX;
                end
                FIX: begin
                    if (op_q[1] == 1'b0) begin
                        res_hi_d = prod_fix[63:32];
                        res_lo_d = prod_fix[31:0];
                    end else begin
                        res_hi_d = rem_fix;
                        res_lo_d = quo_fix;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            acc_q    <= 64'd0;
            opr_q    <= 32'd0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
            op_q     <= OP_MULT;
            done_q   <= 1'b0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opr_q    <= opr_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            dz_q     <= dz_d;
            op_q     <= op_d;
            done_q   <= done_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign Res_hiE = res_hi_q;
    assign Res_loE = res_lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases, abort/reset, then random ops
// checked against a plain-arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA, srcB;
    logic        ErrorFlush;
    logic        busy, done;
    logic [31:0] Res_hiE, Res_loE;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    mul_div_unit #(.ITER(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .ErrorFlush(ErrorFlush), .busy(busy), .done(done), .Res_hiE(Res_hiE), .Res_loE(Res_loE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: {hi, lo} from MIPS semantics using wide integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: ref_model = 64'(sa * sb);
            2'b01: ref_model = ua * ub;
            2'b10: begin
                if (b == 32'd0) ref_model = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) ref_model = {a, 32'hFFFF_FFFF};
                else ref_model = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("res_hi", Res_hiE, e[63:32]);
                chk("res_lo", Res_loE, e[31:0]);
            end
        end
    end

    // Called at a negedge with the unit idle (or in its done cycle); returns at the done-cycle negedge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
        int n;
        bit ended;
        start = 1'b1; op = o; srcA = a; srcB = b;
        exp_q.push_back(ref_model(o, a, b));
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        ended = 1'b0;
        for (int k = 0; k < 100 && !ended; k++) begin
            @(negedge clk);
            if (busy) begin
                n++;
                if (poke && n == 5) begin start = 1'b1; op = ~o; srcA = ~a; srcB = 32'd3; end
                if (poke && n == 6) start = 1'b0;
            end else begin
                ended = 1'b1;
            end
        end
        chk("busy_len", 32'(n), 32'd33);
        chk("done_at_idle", {31'd0, done}, 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: pick = 32'd0;
            1: pick = 32'd1;
            2: pick = 32'hFFFF_FFFF;
            3: pick = 32'h8000_0000;
            4: pick = 32'(int'($urandom_range(0, 20)) - 10);
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0; ErrorFlush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", Res_hiE, 32'd0);
        chk("rst_lo", Res_loE, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed corners, issued back-to-back from each done cycle.
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b11, 32'h1234_5678, 32'd0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'd0, 1'b0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);
        run_op(2'b11, 32'd100, 32'd7, 1'b0);

        // Abort mid-calculation: no done, previous result held.
        start = 1'b1; op = 2'b01; srcA = 32'd5; srcB = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        ErrorFlush = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        ErrorFlush = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_hi", Res_hiE, 32'd2);
        chk("flush_lo", Res_loE, 32'd14);
        repeat (40) @(negedge clk);
        chk("flush_hold_lo", Res_loE, 32'd14);

        // Reset mid-calculation returns everything to reset values.
        start = 1'b1; op = 2'b01; srcA = 32'd5; srcB = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1; start = 1'b1; ErrorFlush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; ErrorFlush = 1'b0;
        @(negedge clk);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_hi", Res_hiE, 32'd0);
        chk("mrst_lo", Res_loE, 32'd0);
        repeat (40) @(negedge clk);
        chk("mrst_idle", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] ro;
            ro = 2'($urandom_range(0, 3));
            run_op(ro, pick(), pick(), (i % 7) == 3);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit in the EX stage, directly upstream of the EX/MEM pipeline register. It executes MIPS `mult`, `multu`, `div` and `divu` over 32 iterations and drives `Res_hiE`/`Res_loE`, which the EX/MEM register latches for later HI/LO write-back. While an operation is in flight it holds `busy`; the hazard unit uses `busy` to stall IF/ID/EX. An exception flush (`ErrorFlush`) aborts the operation.

## Interface
- `ITER`, default 32: iteration count. Fixed at operand width; other values are unsupported.

- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a new operation; sampled only in IDLE.
- `op` in 2: 00 `mult`, 01 `multu`, 10 `div`, 11 `divu`.
- `srcA` in 32: multiplicand or dividend.
- `srcB` in 32: multiplier or divisor.
- `ErrorFlush` in 1: abort the in-flight operation.
- `busy` out 1: high while state ≠ IDLE.
- `done` out 1: one-cycle pulse; results are valid in the same cycle.
- `Res_hiE` out 32: product[63:32] for multiply, remainder for divide.
- `Res_loE` out 32: product[31:0] for multiply, quotient for divide.

## Operation
- States: IDLE, CALC, FIX. Support registers:
  - 6-bit `cnt`.
  - 64-bit accumulator `acc`.
  - 32-bit operand register `opr`.
  - Flags `negQ`/`negR` (or `negP`).
  - Latched `op`.
- IDLE, `start`=1 and `ErrorFlush`=0:
  - Capture the operands into `acc` and `opr`. For signed ops, capture magnitudes: two's-complement negate when bit 31 is set. 0x80000000 has magnitude 0x80000000 as unsigned.
  - Signed multiply: `negP` = `srcA[31]` ^ `srcB[31]`.
  - Signed divide: `negQ` = `srcA[31]` ^ `srcB[31]`, `negR` = `srcA[31]`.
  - Set `cnt`=0 and go to CALC.
- CALC: one iteration per cycle, `cnt`++. Leave for FIX after the iteration with `cnt`=31.
  - Multiply: shift-add, LSB-first. Use a 33-bit add into `acc[63:32]`, then shift `acc` right by 1.
  - Divide: restoring division. Shift `acc` left by 1 and trial-subtract `opr` from `acc[63:32]`. If non-negative, keep the difference and set `acc[0]`=1.
- FIX:
  - Apply sign correction: negate the 64-bit product if `negP`; negate the quotient if `negQ` and the remainder if `negR`.
  - Load `Res_hiE`/`Res_loE`, pulse `done`, and go to IDLE.
- Divide by zero (`srcB`=0), both `div` and `divu`: `Res_loE`=0xFFFFFFFF, `Res_hiE`=`srcA` (raw, unmodified). The iterations still run; FIX overrides the result.
- Signed overflow 0x80000000 / 0xFFFFFFFF: `Res_loE`=0x80000000, `Res_hiE`=0.
- `start` while `busy` is ignored. The request is not queued.
- `ErrorFlush`=1 in any state: next state IDLE, no `done`, `Res_hiE`/`Res_loE` unchanged. `ErrorFlush` beats `start` in the same cycle.
- `Res_hiE`/`Res_loE` hold the last completed result until the next FIX.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `Res_hiE`=0, `Res_loE`=0, `cnt`=0, `acc`=0.
- `start` sampled at edge T:
  - CALC occupies cycles T..T+32 (32 iterations, edges T+1..T+32).
  - FIX is the cycle after edge T+32.
  - Results and `done` appear after edge T+33, for exactly one cycle.
- `busy` is high for 33 cycles, from after edge T through edge T+33. It is low in the `done` cycle.
- Back-to-back: `start` in the `done` cycle is accepted, giving the same 33-cycle `busy`.
- `rst` beats everything, including `ErrorFlush` and `start`. Reset mid-operation returns to the reset values at the next edge.
- `done` is registered, never combinational from inputs.

## Test plan
- `multu` 0xFFFFFFFF × 0xFFFFFFFF → after 33 busy cycles, `done`=1, `Res_hiE`=0xFFFFFFFE, `Res_loE`=0x00000001.
- `mult` −3 × 7 → `Res_hiE`=0xFFFFFFFF, `Res_loE`=0xFFFFFFEB.
- `div` −7 / 2 → `Res_loE`=0xFFFFFFFD, `Res_hiE`=0xFFFFFFFF.
- `div` 0x80000000 / 0xFFFFFFFF → lo 0x80000000, hi 0.
- `divu` 0x12345678 / 0 → lo 0xFFFFFFFF, hi 0x12345678.
- Abort and restart:
  - `divu` 100/7 completes: hi 2, lo 14.
  - Start `multu` 5×6 and assert `ErrorFlush` at CALC cycle 10. Expect `busy`=0 next cycle, no `done`, outputs still 2/14.
  - Restart `multu` 5×6 and assert `rst` at cycle 20. Expect all outputs 0 next cycle.
  - Issue `start` while busy: must be ignored.
